// File: rtl/forward_pipe_pkg.sv
// Shared constants and helpers for the forward register-slice chain.
package forward_pipe_pkg;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 16;

  // Width needed to count 0..stages inclusive.
  function automatic int cnt_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/forward_pipe_if.sv
// Stream, flush and occupancy bundle between a producer/consumer pair and the chain.
interface forward_pipe_if
  import forward_pipe_pkg::*;
#(
  parameter int L      = 8,
  parameter int STAGES = 2
);
  localparam int CW = cnt_width(STAGES);

  logic          flush;
  logic          valid_f;
  logic [L-1:0]  data_f;
  logic          ready_f;
  logic          valid_b;
  logic [L-1:0]  data_b;
  logic          ready_b;
  logic [CW-1:0] occupancy;

  modport master (
    output valid_f, data_f, ready_b, flush,
    input  ready_f, valid_b, data_b, occupancy
  );

  modport slave (
    input  valid_f, data_f, ready_b, flush,
    output ready_f, valid_b, data_b, occupancy
  );

endinterface

// File: rtl/forward_pipe_stage.sv
// One forward register slice: registers valid/data, passes ready combinationally.
module forward_pipe_stage #(
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [L-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [L-1:0] out_data,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  // Slice register; data only loads on a valid word so bubbles do not toggle it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= {L{1'b0}};
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/forward_pipe_chain.sv
// Chain of STAGES forward slices with bubble collapse, flush and an occupancy count.
module forward_pipe_chain
  import forward_pipe_pkg::*;
#(
  parameter int L      = 8,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  forward_pipe_if.slave  bus
);

  localparam int CW = cnt_width(STAGES);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("forward_pipe_chain: STAGES out of range 1..16");
  end

  logic [STAGES-1:0] v;
  logic [L-1:0]      d [STAGES];
  logic [CW-1:0]     occ_r;
  logic              up_fire;
  logic              dn_fire;

  // Each stage owns its ready net so the ready chain has no self-referencing vector.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic         rdy;
    logic         nxt_rdy;
    logic         in_v;
    logic [L-1:0] in_d;

    if (k == 0) begin : g_head
      assign in_v = bus.valid_f;
      assign in_d = bus.data_f;
    end else begin : g_body
      assign in_v = v[k-1];
      assign in_d = d[k-1];
    end

    if (k == STAGES - 1) begin : g_tail
      assign nxt_rdy = bus.ready_b;
    end else begin : g_link
      assign nxt_rdy = g_stage[k+1].rdy;
    end

    forward_pipe_stage #(.L(L)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.flush),
      .in_valid  (in_v),
      .in_data   (in_d),
      .in_ready  (rdy),
      .out_valid (v[k]),
      .out_data  (d[k]),
      .out_ready (nxt_rdy)
    );
  end

  assign bus.ready_f = g_stage[0].rdy;
  assign up_fire     = bus.valid_f && g_stage[0].rdy;
  assign dn_fire     = v[STAGES-1] && bus.ready_b;

  // Occupancy tracks popcount(v); flush wins over any simultaneous fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_r <= {CW{1'b0}};
    end else if (bus.flush) begin
      occ_r <= {CW{1'b0}};
    end else if (up_fire && !dn_fire) begin
      occ_r <= occ_r + CW'(1'b1);
    end else if (dn_fire && !up_fire) begin
      occ_r <= occ_r - CW'(1'b1);
    end else begin
      occ_r <= occ_r;
    end
  end

  assign bus.valid_b   = v[STAGES-1];
  assign bus.data_b    = d[STAGES-1];
  assign bus.occupancy = occ_r;

endmodule

// File: tb/tb_forward_pipe_chain.sv
// Self-checking bench: vector table, reset sequence and randomized run against a word-position model.
module tb_forward_pipe_chain;

  localparam int S2 = 2;

  logic clk;
  logic rst;

  forward_pipe_if #(.L(8), .STAGES(2)) bus2 ();
  forward_pipe_if #(.L(8), .STAGES(3)) bus3 ();

  forward_pipe_chain #(.L(8), .STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  forward_pipe_chain #(.L(8), .STAGES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    bit       on3;
    bit       vf;
    bit [7:0] df;
    bit       rb;
    bit       fl;
    bit       rf;
    bit       vb;
    bit [7:0] db;
    int       occ;
  } vec_t;

  vec_t tbl[$];

  // Words in flight, head first; pos is the stage index the word occupies.
  typedef struct {
    bit [7:0] d;
    int       pos;
  } w_t;

  w_t mq[$];

  task automatic model_edge(input bit up, input bit [7:0] din, input bit rb, input bit fl);
    w_t nq[$];
    int lim;
    int np;
    if (fl) begin
      mq.delete();
      return;
    end
    lim = S2;
    foreach (mq[i]) begin
      if (i == 0 && mq[i].pos == S2 - 1 && rb) begin
        lim = S2;
      end else begin
        np = (mq[i].pos + 1 < lim - 1) ? mq[i].pos + 1 : lim - 1;
        nq.push_back('{d: mq[i].d, pos: np});
        lim = np;
      end
    end
    if (up) nq.push_back('{d: din, pos: 0});
    mq = nq;
  endtask

  task automatic add(input bit on3, input bit vf, input bit [7:0] df, input bit rb, input bit fl,
                     input bit rf, input bit vb, input bit [7:0] db, input int occ);
    tbl.push_back('{on3: on3, vf: vf, df: df, rb: rb, fl: fl, rf: rf, vb: vb, db: db, occ: occ});
  endtask

  task automatic idle_inputs();
    bus2.valid_f = 1'b0; bus2.data_f = 8'h00; bus2.ready_b = 1'b0; bus2.flush = 1'b0;
    bus3.valid_f = 1'b0; bus3.data_f = 8'h00; bus3.ready_b = 1'b0; bus3.flush = 1'b0;
  endtask

  initial begin
    bit       vf;
    bit       rb;
    bit       fl;
    bit [7:0] df;
    bit       exp_rf;
    bit       exp_vb;

    idle_inputs();
    rst = 1'b0;
    #2;
    chk("reset_valid_b", bus2.valid_b, 0);
    chk("reset_data_b", bus2.data_b, 0);
    chk("reset_occ", bus2.occupancy, 0);
    chk("reset_ready_f", bus2.ready_f, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Streaming 0x01..0x10 through STAGES=2 with ready_b held high
    for (int i = 0; i < 18; i++)
      add(0, i < 16, 8'(i + 1), 1, 0, 1, (i >= 1 && i <= 16), 8'(i), (i == 0) ? 1 : (i <= 15) ? 2 : (i == 16) ? 1 : 0);
    // Back-pressure: fill, stall 5 cycles, release
    add(0, 1, 8'hA5, 0, 0, 1, 0, 8'h00, 1);
    add(0, 1, 8'h5A, 0, 0, 1, 1, 8'hA5, 2);
    for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 2);
    add(0, 0, 8'h00, 1, 0, 1, 1, 8'h5A, 1);
    add(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    // Simultaneous fires, then flush with an offered word
    add(0, 1, 8'hC3, 1, 0, 1, 0, 8'h00, 1);
    add(0, 0, 8'h00, 1, 0, 1, 1, 8'hC3, 1);
    add(0, 1, 8'h3C, 1, 0, 1, 0, 8'h00, 1);
    add(0, 1, 8'h99, 0, 1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    // Bubble collapse on STAGES=3 with ready_b low, then drain
    add(1, 1, 8'h11, 0, 0, 1, 0, 8'h00, 1);
    add(1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1);
    add(1, 0, 8'h00, 0, 0, 1, 1, 8'h11, 1);
    add(1, 1, 8'h22, 0, 0, 1, 1, 8'h11, 2);
    add(1, 1, 8'h33, 0, 0, 1, 1, 8'h11, 3);
    add(1, 1, 8'h44, 0, 0, 0, 1, 8'h11, 3);
    add(1, 0, 8'h00, 1, 0, 1, 1, 8'h22, 2);
    add(1, 0, 8'h00, 1, 0, 1, 1, 8'h33, 1);
    add(1, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      if (tbl[i].on3) begin
        bus3.valid_f = tbl[i].vf; bus3.data_f = tbl[i].df; bus3.ready_b = tbl[i].rb; bus3.flush = tbl[i].fl;
        #1 chk($sformatf("v%0d_ready_f", i), bus3.ready_f, tbl[i].rf);
        @(posedge clk); #1;
        chk($sformatf("v%0d_valid_b", i), bus3.valid_b, tbl[i].vb);
        chk($sformatf("v%0d_occ", i), bus3.occupancy, tbl[i].occ);
        if (tbl[i].vb) chk($sformatf("v%0d_data_b", i), bus3.data_b, tbl[i].db);
      end else begin
        bus2.valid_f = tbl[i].vf; bus2.data_f = tbl[i].df; bus2.ready_b = tbl[i].rb; bus2.flush = tbl[i].fl;
        #1 chk($sformatf("v%0d_ready_f", i), bus2.ready_f, tbl[i].rf);
        @(posedge clk); #1;
        chk($sformatf("v%0d_valid_b", i), bus2.valid_b, tbl[i].vb);
        chk($sformatf("v%0d_occ", i), bus2.occupancy, tbl[i].occ);
        if (tbl[i].vb) chk($sformatf("v%0d_data_b", i), bus2.data_b, tbl[i].db);
      end
    end

    // Reset mid-cycle with two words in flight
    @(negedge clk);
    idle_inputs();
    bus2.valid_f = 1'b1; bus2.data_f = 8'hE1;
    @(negedge clk);
    bus2.data_f = 8'hE2;
    @(posedge clk); #3;
    chk("pre_rst_occ", bus2.occupancy, 2);
    rst = 1'b0;
    #1;
    chk("rst_async_valid_b", bus2.valid_b, 0);
    chk("rst_async_data_b", bus2.data_b, 0);
    chk("rst_async_occ", bus2.occupancy, 0);
    chk("rst_async_ready_f", bus2.ready_f, 1);
    @(posedge clk); #1;
    chk("rst_hold_occ", bus2.occupancy, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    mq.delete();

    // Randomized run against the word-position model
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      vf = ($urandom_range(0, 3) != 0);
      df = 8'($urandom);
      rb = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 63) == 0);
      bus2.valid_f = vf; bus2.data_f = df; bus2.ready_b = rb; bus2.flush = fl;
      #1;
      exp_rf = (mq.size() < S2) || rb;
      chk("rnd_ready_f", bus2.ready_f, exp_rf);
      @(posedge clk);
      model_edge(vf && exp_rf, df, rb, fl);
      #1;
      exp_vb = (mq.size() > 0) && (mq[0].pos == S2 - 1);
      chk("rnd_valid_b", bus2.valid_b, exp_vb);
      chk("rnd_occ", bus2.occupancy, mq.size());
      if (exp_vb) chk("rnd_data_b", bus2.data_b, mq[0].d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/forward_pipe_chain.md
Name: forward_pipe_chain

Overview:
- Parameterisable chain of forward register slices on a valid/ready stream. Each slice registers valid and data; ready is combinational.
- It is the forward-direction counterpart of the team's backward skid buffer. Designers place the two in series to break both the forward and the backward timing paths.
- Empty stages collapse bubbles. An occupancy count and a synchronous flush support debug and pipeline drains.

Parameters:
- L, 8, data width in bits.
- STAGES, 2, number of register slices. Legal range is 1..16; elaboration must fail outside that range.
- CW, $clog2(STAGES+1), occupancy counter width. This is derived and must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all stages.
- valid_f  input  1  upstream valid.
- data_f  input  L  upstream data.
- ready_f  output  1  upstream ready (combinational).
- valid_b  output  1  downstream valid (registered, last stage).
- data_b  output  L  downstream data (registered, last stage).
- ready_b  input  1  downstream ready.
- occupancy  output  CW  number of valid stages (registered).

Behaviour:
- Reset: clk and rst are the single clock and the async active-low reset. While rst=0, every stage valid v[k]=0, data d[k]=0 and occupancy=0, immediately and without waiting for clk. Consequently valid_b=0, data_b=0 and ready_f=1 during reset. Deassertion is used synchronously, with no glitch on outputs.
- Stage indexing: stage 0 is next to upstream and stage STAGES-1 drives valid_b/data_b.
- Readiness:
  - r[STAGES]=ready_b.
  - r[k] = !v[k] || r[k+1].
  - ready_f = r[0].
  - The ready path is purely combinational, so a bubble anywhere makes ready_f high.
- Per-stage update on a clock edge, when r[k+1] is true or v[k] is false:
  - v[k] <= input valid of stage k.
  - d[k] <= input data of stage k, loaded only when the input valid is 1. Otherwise d[k] holds, so no toggling on bubbles.
  - The input of stage 0 is valid_f/data_f; the input of stage k>0 is v[k-1]/d[k-1].
- Hold rule: when v[k]=1 and r[k+1]=0, v[k] and d[k] hold.
  - valid_b/data_b must be stable while valid_b=1 and ready_b=0.
  - Data is never dropped or duplicated.
- Fire events:
  - up_fire = valid_f && ready_f.
  - dn_fire = valid_b && ready_b.
  - The block must produce no combinational path from valid_f to valid_b.
- Latency and throughput:
  - Empty chain: a word accepted at edge N appears on valid_b after edge N+STAGES-1, i.e. valid_b is first high in the cycle after STAGES edges.
  - Sustained throughput is 1 word/cycle with ready_b held at 1.
- Occupancy:
  - Increments by 1 on up_fire only and decrements by 1 on dn_fire only; both or neither leaves it unchanged.
  - It must always equal popcount(v).
  - It never exceeds STAGES and never underflows.
- Flush:
  - flush=1 at an edge clears all v[k] and sets occupancy to 0.
  - Flush takes precedence over simultaneous up_fire/dn_fire. The word offered in that cycle is discarded even though ready_f may read 1.
  - d[k] is not cleared by flush.
- Full condition: all v[k]=1 and ready_b=0 gives ready_f=0. ready_b rising makes ready_f rise in the same cycle.
- Reset mid-stream: all in-flight words are lost, outputs go to reset values, and no fire is counted.

Decomposition:
- Shared package forward_pipe_pkg: the STAGES bound constants (STAGES_MIN=1, STAGES_MAX=16) and a function returning the count width for a given STAGES.
- Sub-module forward_pipe_stage (parameter L): one registered slice with ports in_valid, in_data, in_ready, out_valid, out_data, out_ready, plus flush.
- forward_pipe_chain instantiates STAGES copies with a generate loop and contains the occupancy counter.

Test Plan:
- Reset: assert rst=0 mid-cycle with 2 words in flight -> valid_b=0, data_b=0, occupancy=0 and ready_f=1 immediately, before the next clk edge.
- Streaming, STAGES=2, ready_b=1, valid_f=1 with data 0x01..0x10 on consecutive cycles -> valid_b first high after 2 edges. Outputs are 0x01..0x10 in order with no gaps, and occupancy is steady at 2.
- Back-pressure: fill with 0xA5,0x5A, then ready_b=0 for 5 cycles -> ready_f=0, data_b=0xA5 stable, occupancy=2. Raising ready_b gives ready_f=1 in the same cycle and 0xA5 then 0x5A delivered.
- Bubble collapse, STAGES=3: send 0x11, idle 2 cycles, send 0x22, with ready_b=0 throughout -> 0x22 enters behind 0x11 and occupancy=2. ready_f stays 1 until all 3 stages are valid.
- Simultaneous events: at occupancy=1, apply up_fire and dn_fire in the same cycle -> occupancy stays 1. Then assert flush together with up_fire -> occupancy=0, valid_b=0, and the offered word never appears.
- Random: 10k cycles of random valid_f/ready_b/flush, checked against a queue scoreboard -> no loss, duplication or reordering; occupancy==popcount(v); and the hold rule is never violated.
